// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-RAM arbiter.
package dmem_arb_pkg;

   localparam int AW_DEF     = 16;
   localparam int DW_DEF     = 8;
   localparam int STARVE_DEF = 8;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_LDR
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE_CPU,
      ST_ISSUE_LDR
   } state_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts loader arbitration losses and raises force_ldr at the limit.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic ldr_req,
   input  logic ldr_win,
   input  logic cpu_lock,
   output logic force_ldr
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt;

   assign force_ldr = (cnt == CW'(STARVE_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ldr_win) begin
         cnt <= '0;
      end else if (ldr_req && !cpu_lock && !force_ldr) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between CPU and image loader.
// Optional loader starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
`ifdef DMEM_ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_MAX = STARVE_DEF
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_lock,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          busy
);

   state_e state;
   owner_e owner;
   logic   force_ldr;
   logic   cpu_win;
   logic   ldr_win;
   logic   rd_issued;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   dmem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .ldr_req  (ldr_req),
      .ldr_win  (ldr_win),
      .cpu_lock (cpu_lock),
      .force_ldr(force_ldr)
   );
`else
   assign force_ldr = 1'b0;
`endif

   // Lock shuts the loader out entirely; otherwise CPU wins unless forced.
   assign ldr_win   = ldr_req && !cpu_lock && (!cpu_req || force_ldr);
   assign cpu_win   = cpu_req && !ldr_win;
   assign mem_en    = (state != ST_IDLE);
   assign rd_issued = mem_en && !mem_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_gnt    <= 1'b0;
         ldr_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         ldr_rvalid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // owner acts as the read tag: RAM data lands one cycle after issue
         cpu_rvalid <= rd_issued && (owner == OWN_CPU);
         ldr_rvalid <= rd_issued && (owner == OWN_LDR);
         busy       <= cpu_win || ldr_win || rd_issued;
         unique case (1'b1)
            cpu_win: begin
               state     <= ST_ISSUE_CPU;
               owner     <= OWN_CPU;
               mem_we    <= cpu_we;
               mem_addr  <= cpu_addr;
               mem_wdata <= cpu_wdata;
               cpu_gnt   <= 1'b1;
               ldr_gnt   <= 1'b0;
            end
            ldr_win: begin
               state     <= ST_ISSUE_LDR;
               owner     <= OWN_LDR;
               mem_we    <= ldr_we;
               mem_addr  <= ldr_addr;
               mem_wdata <= ldr_wdata;
               cpu_gnt   <= 1'b0;
               ldr_gnt   <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               owner     <= OWN_NONE;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               cpu_gnt   <= 1'b0;
               ldr_gnt   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync RAM.
module tb_dmem_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_lock;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic          ldr_req, ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_gnt, ldr_rvalid;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic          c_req;
      logic          c_we;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wd;
      logic          lock;
      logic          l_req;
      logic          l_we;
      logic [AW-1:0] l_addr;
      logic [DW-1:0] l_wd;
      logic [27:0]   exp;
   } vec_t;

   vec_t vt [8];

   dmem_arbiter #(
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_lock  (cpu_lock),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .ldr_req   (ldr_req),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_gnt   (ldr_gnt),
      .ldr_rvalid(ldr_rvalid),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   function automatic logic [27:0] outs();
      return {cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      cpu_lock = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      int gl, nc, hit;
      ram[16'h0004] = 8'hA5;
      ram[16'h0008] = 8'h18;
      ram[16'h0009] = 8'h19;
      ram[16'h0010] = 8'h42;

      vt[0] = '{0,0,16'h0000,8'h00,0,0,0,16'h0000,8'h00,
                {1'b0,1'b0,1'b0,1'b0,16'h0000,8'h00}};
      vt[1] = '{1,1,16'h0020,8'h5A,0,0,0,16'h0000,8'h00,
                {1'b1,1'b0,1'b1,1'b1,16'h0020,8'h5A}};
      vt[2] = '{0,0,16'h0000,8'h00,0,1,0,16'h0300,8'h77,
                {1'b0,1'b1,1'b1,1'b0,16'h0300,8'h77}};
      vt[3] = '{1,0,16'h0040,8'h00,0,1,1,16'h0050,8'h99,
                {1'b1,1'b0,1'b1,1'b0,16'h0040,8'h00}};
      vt[4] = '{1,1,16'h0060,8'h12,1,1,0,16'h0070,8'h00,
                {1'b1,1'b0,1'b1,1'b1,16'h0060,8'h12}};
      vt[5] = '{0,0,16'h0000,8'h00,1,1,1,16'h0080,8'h34,
                {1'b0,1'b0,1'b0,1'b0,16'h0000,8'h00}};
      vt[6] = '{1,0,16'h0090,8'h00,1,0,0,16'h0000,8'h00,
                {1'b1,1'b0,1'b1,1'b0,16'h0090,8'h00}};
      vt[7] = '{0,0,16'h0000,8'h00,0,1,1,16'h0123,8'hEE,
                {1'b0,1'b1,1'b1,1'b1,16'h0123,8'hEE}};

      do_reset();
      chk("reset_state", {outs(), cpu_rvalid, ldr_rvalid, busy}, 0);

      for (int i = 0; i < 8; i++) begin
         cpu_req = vt[i].c_req;  cpu_we = vt[i].c_we;
         cpu_addr = vt[i].c_addr; cpu_wdata = vt[i].c_wd;
         cpu_lock = vt[i].lock;
         ldr_req = vt[i].l_req;  ldr_we = vt[i].l_we;
         ldr_addr = vt[i].l_addr; ldr_wdata = vt[i].l_wd;
         tick();
         chk($sformatf("vec%0d", i), outs(), vt[i].exp);
      end
      clr_in();
      tick();
      tick();

      // single CPU read, one-cycle latency
      cpu_req = 1; cpu_addr = 16'h0004;
      tick();
      chk("rd_issue", outs(), {1'b1,1'b0,1'b1,1'b0,16'h0004,8'h00});
      clr_in();
      tick();
      chk("rd_rvalid", {cpu_rvalid, ldr_rvalid, busy, mem_rdata},
          {1'b1, 1'b0, 1'b1, 8'hA5});
      tick();
      chk("rd_done", {cpu_rvalid, busy, mem_en}, 0);

      // simultaneous requests: CPU first, LDR next with CPU rvalid
      cpu_req = 1; cpu_addr = 16'h0008;
      ldr_req = 1; ldr_addr = 16'h0009;
      tick();
      chk("both_first", {cpu_gnt, ldr_gnt}, 2'b10);
      cpu_req = 0;
      tick();
      chk("both_second", {ldr_gnt, cpu_gnt, cpu_rvalid, mem_rdata, mem_addr},
          {1'b1, 1'b0, 1'b1, 8'h18, 16'h0009});
      clr_in();
      tick();
      chk("both_ldr_rd", {ldr_rvalid, cpu_rvalid, mem_rdata},
          {1'b1, 1'b0, 8'h19});
      tick();

      // reset asserted while a CPU read is outstanding
      cpu_req = 1; cpu_addr = 16'h0010;
      tick();
      chk("mid_rd_gnt", {cpu_gnt, mem_en}, 2'b11);
      clr_in();
      #2 rst = 1;
      #1;
      chk("mid_rst_outs", {outs(), cpu_rvalid, ldr_rvalid, busy}, 0);
      tick();
      rst = 0;
      hit = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cpu_rvalid || ldr_rvalid) hit++;
      end
      chk("mid_rst_no_rv", hit, 0);

      // locked RAM holds off the loader
      cpu_lock = 1;
      ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0100; ldr_wdata = 8'h3C;
      gl = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ldr_gnt) gl++;
      end
      chk("lock_no_gnt", gl, 0);
      cpu_lock = 0;
      tick();
      chk("lock_release", outs(), {1'b0,1'b1,1'b1,1'b1,16'h0100,8'h3C});
      clr_in();
      tick();
      chk("lock_ram_wr", ram[16'h0100], 8'h3C);

      // back-to-back write then read of the same address
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0001; cpu_wdata = 8'h11;
      tick();
      chk("b2b_wr", outs(), {1'b1,1'b0,1'b1,1'b1,16'h0001,8'h11});
      cpu_we = 0; cpu_wdata = 8'h00;
      tick();
      chk("b2b_rd", outs(), {1'b1,1'b0,1'b1,1'b0,16'h0001,8'h00});
      clr_in();
      tick();
      chk("b2b_rdata", {cpu_rvalid, ldr_rvalid, mem_rdata},
          {1'b1, 1'b0, 8'h11});

      // continuous CPU traffic against a waiting loader
      do_reset();
      cpu_req = 1; cpu_addr = 16'h0002;
      ldr_req = 1; ldr_addr = 16'h0003;
      nc = 0;
      gl = 0;
      for (int i = 0; i < 20 && gl == 0; i++) begin
         tick();
         if (ldr_gnt) gl = 1;
         else if (cpu_gnt) nc++;
      end
`ifdef DMEM_ARB_STARVE_GUARD_EN
      chk("starve_cpu_wins", nc, 8);
      chk("starve_ldr_gnt", gl, 1);
`else
      chk("starve_cpu_wins", nc, 20);
      chk("starve_ldr_gnt", gl, 0);
`endif
      clr_in();
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
